// File: rtl/video_pattern_gen.sv
// Test-pattern source: turns the raw hsync/vsync/data_en stream from video_timing into an
// RGB pixel stream. It tracks pixel, line and frame coordinates and applies the pattern
// latched at frame start.
// Latency: fixed 2 clocks on all outputs. There is no backpressure: a new input is accepted every clock.
// Ports: clk/reset (sync, active-high); hsync/vsync/data_en timing in; pattern_sel (latched at
//        frame start); hsync_out/vsync_out/data_en_out delayed syncs; rgb {R,G,B} aligned with data_en_out.
module video_pattern_gen #(
  parameter int   X_BITS      = 12,
  parameter int   Y_BITS      = 11,
  parameter int   BAR_WIDTH   = 80,
  parameter int   CHECK_LOG2  = 5,
  parameter logic SYNC_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        data_en,
  input  logic [1:0]  pattern_sel,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        data_en_out,
  output logic [23:0] rgb
);

  localparam int BC_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(BAR_WIDTH - 1);

  // Coordinate state
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [7:0]        frame_q, frame_d;
  logic [BC_W-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [1:0]        pat_q, pat_d;
  logic              vs_prev_q, de_prev_q;
  logic              frame_start, de_fall;

  // Stage 1: registered syncs plus the coordinates belonging to that pixel
  logic       s1_hs_q, s1_vs_q, s1_de_q;
  logic [7:0] s1_xlo_q, s1_ylo_q, s1_frame_q;
  logic       s1_xck_q, s1_yck_q;
  logic [2:0] s1_bar_q;
  logic [1:0] s1_pat_q;

  // Stage 2: outputs
  logic        hs2_q, vs2_q, de2_q;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    frame_d   = frame_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    pat_d     = pat_q;

    if (data_en) begin
      x_d = x_q + X_BITS'(1);
      if (bar_cnt_q == BC_MAX) begin
        bar_cnt_d = '0;
        // The last bar stretches to the end of the line.
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BC_W'(1);
      end
    end else begin
      x_d       = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end

    frame_start = (vs_prev_q != SYNC_ACTIVE) && (vsync == SYNC_ACTIVE);
    de_fall     = de_prev_q && !data_en;

    // Frame start takes priority so a coincident line end still leaves y at 0.
    if (frame_start) begin
      y_d     = '0;
      frame_d = frame_q + 8'd1;
      pat_d   = pattern_sel;
    end else if (de_fall) begin
      y_d = y_q + Y_BITS'(1);
    end
  end

  always_comb begin
    rgb_d = 24'h000000;
    case (s1_pat_q)
      2'd0: begin
        case (s1_bar_q)
          3'd0:    rgb_d = 24'hFFFFFF;
          3'd1:    rgb_d = 24'hFFFF00;
          3'd2:    rgb_d = 24'h00FFFF;
          3'd3:    rgb_d = 24'h00FF00;
          3'd4:    rgb_d = 24'hFF00FF;
          3'd5:    rgb_d = 24'hFF0000;
          3'd6:    rgb_d = 24'h0000FF;
          default: rgb_d = 24'h000000;
        endcase
      end
      2'd1:    rgb_d = {s1_xlo_q, s1_ylo_q, s1_frame_q};
      2'd2:    rgb_d = (s1_xck_q ^ s1_yck_q) ? 24'h000000 : 24'hFFFFFF;
      default: rgb_d = 24'hFFFFFF;
    endcase
    if (!s1_de_q) rgb_d = 24'h000000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      frame_q    <= '0;
      bar_cnt_q  <= '0;
      bar_idx_q  <= '0;
      pat_q      <= '0;
      vs_prev_q  <= ~SYNC_ACTIVE;
      de_prev_q  <= 1'b0;
      s1_hs_q    <= ~SYNC_ACTIVE;
      s1_vs_q    <= ~SYNC_ACTIVE;
      s1_de_q    <= 1'b0;
      s1_xlo_q   <= '0;
      s1_ylo_q   <= '0;
      s1_frame_q <= '0;
      s1_xck_q   <= 1'b0;
      s1_yck_q   <= 1'b0;
      s1_bar_q   <= '0;
      s1_pat_q   <= '0;
      hs2_q      <= ~SYNC_ACTIVE;
      vs2_q      <= ~SYNC_ACTIVE;
      de2_q      <= 1'b0;
      rgb_q      <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      frame_q    <= frame_d;
      bar_cnt_q  <= bar_cnt_d;
      bar_idx_q  <= bar_idx_d;
      pat_q      <= pat_d;
      vs_prev_q  <= vsync;
      de_prev_q  <= data_en;
      // The pixel is coloured with the coordinates in force before this cycle's update.
      s1_hs_q    <= hsync;
      s1_vs_q    <= vsync;
      s1_de_q    <= data_en;
      s1_xlo_q   <= x_q[7:0];
      s1_ylo_q   <= y_q[7:0];
      s1_frame_q <= frame_q;
      s1_xck_q   <= x_q[CHECK_LOG2];
      s1_yck_q   <= y_q[CHECK_LOG2];
      s1_bar_q   <= bar_idx_q;
      s1_pat_q   <= pat_q;
      hs2_q      <= s1_hs_q;
      vs2_q      <= s1_vs_q;
      de2_q      <= s1_de_q;
      rgb_q      <= rgb_d;
    end
  end

  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign data_en_out = de2_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen. Expected outputs go into a queue when each input cycle is
// driven, and a monitor compares them two clocks later. Hand-computed spot values are kept
// in a second queue and checked in the same way.
module tb_video_pattern_gen;
  localparam logic SA = 1'b1;

  logic        clk = 1'b0;
  logic        reset, hsync, vsync, data_en;
  logic [1:0]  pattern_sel;
  logic        hsync_out, vsync_out, data_en_out;
  logic [23:0] rgb;

  video_pattern_gen #(
    .X_BITS(12), .Y_BITS(11), .BAR_WIDTH(80), .CHECK_LOG2(5), .SYNC_ACTIVE(SA)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .data_en(data_en),
    .pattern_sel(pattern_sel), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .data_en_out(data_en_out), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] due;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } exp_t;
  exp_t exp_q[$];

  int          sp_due[$];
  logic [23:0] sp_val[$];
  string       sp_name[$];

  // Pending spot points for the next line: pixel index (== active count means first blank cycle)
  int          pend_x[$];
  logic [23:0] pend_v[$];
  string       pend_n[$];

  // Reference state following the block's behavioural description
  int         m_x, m_y, m_bar_cnt, m_bar_idx;
  logic [7:0] m_frame;
  logic [1:0] m_pat, sel;
  logic       m_pvs, m_pde;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] model_colour();
    logic [11:0] xv;
    logic [10:0] yv;
    xv = m_x[11:0];
    yv = m_y[10:0];
    case (m_pat)
      2'd0:    return bars[m_bar_idx];
      2'd1:    return {xv[7:0], yv[7:0], m_frame};
      2'd2:    return (xv[5] ^ yv[5]) ? 24'h000000 : 24'hFFFFFF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_bar_cnt = 0; m_bar_idx = 0;
    m_frame = 8'd0; m_pat = 2'd0; m_pvs = ~SA; m_pde = 1'b0;
  endtask

  task automatic step(input logic r, input logic h, input logic v, input logic d);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; hsync = h; vsync = v; data_en = d; pattern_sel = sel;
    e.due = 32'(cyc + 2);
    if (r) begin
      e.hs = ~SA; e.vs = ~SA; e.de = 1'b0; e.rgb = 24'h0;
      // Reset also wipes the pixel still sitting in the pipeline.
      if (exp_q.size() > 0 && exp_q[$].due == 32'(cyc + 1)) begin
        exp_q[$].hs = ~SA; exp_q[$].vs = ~SA; exp_q[$].de = 1'b0; exp_q[$].rgb = 24'h0;
      end
      model_reset();
    end else begin
      e.hs = h; e.vs = v; e.de = d;
      e.rgb = d ? model_colour() : 24'h0;
      if (d) begin
        m_x = (m_x + 1) % 4096;
        if (m_bar_cnt == 79) begin
          m_bar_cnt = 0;
          if (m_bar_idx < 7) m_bar_idx++;
        end else m_bar_cnt++;
      end else begin
        m_x = 0; m_bar_cnt = 0; m_bar_idx = 0;
      end
      if (m_pvs != SA && v == SA) begin
        m_y = 0; m_frame = m_frame + 8'd1; m_pat = sel;
      end else if (m_pde && !d) begin
        m_y = (m_y + 1) % 2048;
      end
      m_pvs = v; m_pde = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic push_spot(input logic [23:0] v, input string n);
    sp_due.push_back(cyc + 2);
    sp_val.push_back(v);
    sp_name.push_back(n);
  endtask

  task automatic add_spot(input int x, input logic [23:0] v, input string n);
    pend_x.push_back(x); pend_v.push_back(v); pend_n.push_back(n);
  endtask

  task automatic check_pending(input int x);
    for (int k = 0; k < pend_x.size(); k++)
      if (pend_x[k] == x) push_spot(pend_v[k], pend_n[k]);
  endtask

  task automatic line(input int act, input int blank);
    for (int i = 0; i < act; i++) begin
      step(1'b0, ~SA, ~SA, 1'b1);
      check_pending(i);
    end
    for (int j = 0; j < blank; j++) begin
      step(1'b0, (j >= 4 && j < 12) ? SA : ~SA, ~SA, 1'b0);
      if (j == 0) check_pending(act);
    end
    pend_x.delete(); pend_v.delete(); pend_n.delete();
  endtask

  task automatic vframe(input int n);
    for (int i = 0; i < 2; i++) step(1'b0, ~SA, ~SA, 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, ~SA, SA, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, ~SA, ~SA, 1'b0);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if ({hsync_out, vsync_out, data_en_out, rgb} !== {e.hs, e.vs, e.de, e.rgb}) begin
        n_fail++;
        $display("FAIL stream cyc=%0d got hs=%b vs=%b de=%b rgb=%h want hs=%b vs=%b de=%b rgb=%h",
                 cyc, hsync_out, vsync_out, data_en_out, rgb, e.hs, e.vs, e.de, e.rgb);
      end
    end
    while (sp_due.size() > 0 && sp_due[0] == cyc) begin
      logic [23:0] v;
      string       n;
      void'(sp_due.pop_front());
      v = sp_val.pop_front();
      n = sp_name.pop_front();
      n_chk++;
      if (rgb !== v) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got rgb=%h want %h", n, cyc, rgb, v);
      end
    end
  end

  initial begin
    reset = 1'b1; hsync = ~SA; vsync = ~SA; data_en = 1'b0; pattern_sel = 2'd0; sel = 2'd0;
    model_reset();

    // Reset, then release with data_en low
    for (int i = 0; i < 3; i++) step(1'b1, ~SA, ~SA, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, ~SA, ~SA, 1'b0);

    // Gradient, first full frame after reset (frame = 1); vsync held 2 cycles
    sel = 2'd1;
    vframe(2);
    line(320, 20);
    line(320, 20);
    add_spot(5,   24'h050201, "grad_x5");
    add_spot(300, 24'h2C0201, "grad_x300");
    line(320, 20);

    // Colour bars over a 640-pixel line, then an over-long line to check saturation
    sel = 2'd0;
    vframe(3);
    add_spot(0,   24'hFFFFFF, "bar_x0");
    add_spot(79,  24'hFFFFFF, "bar_x79");
    add_spot(80,  24'hFFFF00, "bar_x80");
    add_spot(159, 24'hFFFF00, "bar_x159");
    add_spot(160, 24'h00FFFF, "bar_x160");
    add_spot(559, 24'h0000FF, "bar_x559");
    add_spot(560, 24'h000000, "bar_x560");
    add_spot(639, 24'h000000, "bar_x639");
    add_spot(640, 24'h000000, "bar_blank");
    line(640, 20);
    add_spot(690, 24'h000000, "bar_sat");
    line(700, 20);

    // Checkerboard, 32-pixel squares
    sel = 2'd2;
    vframe(2);
    add_spot(31, 24'hFFFFFF, "chk_y0_x31");
    add_spot(32, 24'h000000, "chk_y0_x32");
    line(64, 16);
    for (int l = 1; l < 32; l++) line(64, 16);
    add_spot(0,  24'h000000, "chk_y32_x0");
    add_spot(32, 24'hFFFFFF, "chk_y32_x32");
    line(64, 16);

    // Solid; pattern_sel changes mid-frame and takes effect only at the next vsync
    sel = 2'd3;
    vframe(2);
    add_spot(85, 24'hFFFFFF, "solid_x85");
    line(100, 16);
    sel = 2'd0;
    add_spot(85, 24'hFFFFFF, "solid_hold_x85");
    line(100, 16);
    vframe(2);
    add_spot(0,  24'hFFFFFF, "newbar_x0");
    add_spot(85, 24'hFFFF00, "newbar_x85");
    line(100, 16);

    // One-cycle reset mid-line with data_en high during a solid frame
    sel = 2'd3;
    vframe(2);
    for (int i = 0; i < 100; i++) step(1'b0, ~SA, ~SA, 1'b1);
    step(1'b1, ~SA, ~SA, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, ~SA, ~SA, 1'b1);
      if (i == 0)  push_spot(24'hFFFFFF, "rst_x0");
      if (i == 85) push_spot(24'hFFFF00, "rst_x85");
    end
    for (int j = 0; j < 16; j++) step(1'b0, ~SA, ~SA, 1'b0);
    line(100, 16);

    for (int i = 0; i < 4; i++) step(1'b0, ~SA, ~SA, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0 || sp_due.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d/%0d entries left want 0/0", exp_q.size(), sp_due.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
